// File: rtl/board_snapshot_reader.sv
`default_nettype none
// ============================================================================
// Module   : board_snapshot_reader
// Purpose  : Captures one frame of life_logic cells (1 bit per cell, LSB-first)
//            into a byte FIFO that drains over a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module board_snapshot_reader #(
    parameter int BOARD_W    = 160,
    parameter int BOARD_H    = 120,
    parameter int CELL_SHIFT = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        blank_in,
    input  logic        alive_in,
    output logic [7:0]  byte_out,
    output logic        byte_valid_out,
    input  logic        byte_ready_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        overflow_out
);
    localparam int c_X_W   = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
    localparam int c_Y_W   = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [10:0]        c_H_MASK = 11'((1 << CELL_SHIFT) - 1);
    localparam logic [9:0]         c_V_MASK = 10'((1 << CELL_SHIFT) - 1);
    localparam logic [10:0]        c_W_LIM  = 11'(BOARD_W);
    localparam logic [9:0]         c_H_LIM  = 10'(BOARD_H);
    localparam logic [c_X_W-1:0]   c_X_LAST = c_X_W'(BOARD_W - 1);
    localparam logic [c_Y_W-1:0]   c_Y_LAST = c_Y_W'(BOARD_H - 1);
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_DRAIN   = 2'd3;

    logic [1:0]         r_state;
    logic [c_X_W-1:0]   r_cell_x;
    logic [c_Y_W-1:0]   r_cell_y;
    logic [7:0]         r_shreg;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [10:0] w_cell_h;
    logic [9:0]  w_cell_v;
    logic        w_sample;
    logic        w_origin;
    logic        w_push_req;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [7:0]  w_push_data;

    // A sample point is the top-left pixel of an on-board cell in active video.
    assign w_cell_h = hcount_in >> CELL_SHIFT;
    assign w_cell_v = vcount_in >> CELL_SHIFT;
    assign w_sample = !blank_in
                      && ((hcount_in & c_H_MASK) == 11'd0)
                      && ((vcount_in & c_V_MASK) == 10'd0)
                      && (w_cell_h < c_W_LIM)
                      && (w_cell_v < c_H_LIM);
    assign w_origin = w_sample && (hcount_in == 11'd0) && (vcount_in == 10'd0);

    assign w_push_req  = (r_state == c_ST_CAPTURE) && w_sample && (r_cell_x[2:0] == 3'd7);
    assign w_push_data = {alive_in, r_shreg[7:1]};
    assign w_full      = (r_count == c_FULL);
    assign w_pop       = byte_valid_out && byte_ready_in;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= c_ST_IDLE;
            r_cell_x   <= '0;
            r_cell_y   <= '0;
            r_shreg    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (start_in) begin
                        r_state    <= c_ST_ARMED;
                        r_busy     <= 1'b1;
                        r_overflow <= 1'b0;
                    end
                end
                c_ST_ARMED: begin
                    if (w_origin) begin
                        r_shreg  <= {alive_in, r_shreg[7:1]};
                        r_cell_x <= c_X_W'(1);
                        r_cell_y <= '0;
                        r_state  <= c_ST_CAPTURE;
                    end
                end
                c_ST_CAPTURE: begin
                    if (w_sample) begin
                        r_shreg <= {alive_in, r_shreg[7:1]};
                        if (r_cell_x == c_X_LAST) begin
                            r_cell_x <= '0;
                            if (r_cell_y == c_Y_LAST) begin
                                r_cell_y <= '0;
                                r_state  <= c_ST_DRAIN;
                            end else begin
                                r_cell_y <= r_cell_y + 1'b1;
                            end
                        end else begin
                            r_cell_x <= r_cell_x + 1'b1;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (r_count == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign byte_valid_out = (r_count != '0);
    assign byte_out       = byte_valid_out ? r_mem[r_rd_ptr] : 8'h00;
    assign busy_out       = r_busy;
    assign done_out       = r_done;
    assign overflow_out   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_board_snapshot_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_snapshot_reader
// Purpose  : Scoreboard bench for board_snapshot_reader on a small shared raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_snapshot_reader;
    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    initial forever begin @(posedge clk); cyc++; end

    // 40x8 pixel raster, 32x4 active
    logic [10:0] hc = 11'd0;
    logic [9:0]  vc = 10'd0;
    logic        blank;
    assign blank = (hc >= 11'd32) || (vc >= 10'd4);
    initial forever begin
        @(posedge clk); #1;
        if (hc == 11'd39) begin
            hc = 11'd0;
            vc = (vc == 10'd7) ? 10'd0 : vc + 10'd1;
        end else begin
            hc = hc + 11'd1;
        end
    end

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic ready_a = 1'b0, ready_c = 1'b0;
    logic ready_b = 1'b1;
    logic mode_a = 1'b0;
    int   rmode_a = 1, rmode_c = 0;
    logic alive_a, alive_b, alive_c;
    logic [7:0] byte_a, byte_b, byte_c;
    logic valid_a, valid_b, valid_c, busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;

    assign alive_a = mode_a ? ((hc == 11'd0 && vc == 10'd0) || (hc == 11'd15 && vc == 10'd1)) : hc[0];
    assign alive_b = hc[0] ^ hc[3] ^ (vc != 10'd0);
    assign alive_c = (hc[2:0] == {1'b0, hc[4:3]});

    // ready: mode 0 low, 1 high, 2 toggles every cycle
    initial forever begin
        @(posedge clk); #1;
        ready_a = (rmode_a == 2) ? ~ready_a : (rmode_a == 1);
        ready_c = (rmode_c != 0);
    end

    board_snapshot_reader #(.BOARD_W(16), .BOARD_H(2), .CELL_SHIFT(0), .FIFO_DEPTH(16)) u_dut_a (
        .clk_in(clk), .rst_in(rst_a), .start_in(start_a), .hcount_in(hc), .vcount_in(vc),
        .blank_in(blank), .alive_in(alive_a), .byte_out(byte_a), .byte_valid_out(valid_a),
        .byte_ready_in(ready_a), .busy_out(busy_a), .done_out(done_a), .overflow_out(ovf_a));
    board_snapshot_reader #(.BOARD_W(8), .BOARD_H(1), .CELL_SHIFT(2), .FIFO_DEPTH(16)) u_dut_b (
        .clk_in(clk), .rst_in(rst_b), .start_in(start_b), .hcount_in(hc), .vcount_in(vc),
        .blank_in(blank), .alive_in(alive_b), .byte_out(byte_b), .byte_valid_out(valid_b),
        .byte_ready_in(ready_b), .busy_out(busy_b), .done_out(done_b), .overflow_out(ovf_b));
    board_snapshot_reader #(.BOARD_W(32), .BOARD_H(1), .CELL_SHIFT(0), .FIFO_DEPTH(2)) u_dut_c (
        .clk_in(clk), .rst_in(rst_c), .start_in(start_c), .hcount_in(hc), .vcount_in(vc),
        .blank_in(blank), .alive_in(alive_c), .byte_out(byte_c), .byte_valid_out(valid_c),
        .byte_ready_in(ready_c), .busy_out(busy_c), .done_out(done_c), .overflow_out(ovf_c));

    int q_a[$], q_b[$], q_c[$];
    bit stall[3];
    int held[3], last_x[3], done_cnt[3];

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    task automatic pop_exp(input int id, output int e, output bit ok);
        ok = 1'b1;
        e  = 0;
        case (id)
            0: if (q_a.size() > 0) e = q_a.pop_front(); else ok = 1'b0;
            1: if (q_b.size() > 0) e = q_b.pop_front(); else ok = 1'b0;
            default: if (q_c.size() > 0) e = q_c.pop_front(); else ok = 1'b0;
        endcase
    endtask

    task automatic monitor_step(input int id, input string nm, input logic r, input logic v,
                                input logic rd, input logic [7:0] b, input logic bz, input logic d);
        int  e;
        bit  ok;
        if (r) begin
            stall[id] = 1'b0;
            return;
        end
        if (stall[id]) begin
            chk({nm, "_hold_valid"}, int'(v), 1);
            chk({nm, "_hold_byte"}, int'(b), held[id]);
        end
        if (v && rd) begin
            pop_exp(id, e, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL %s_extra_byte: got %02h, required no byte", nm, b);
            end else begin
                chk({nm, "_byte"}, int'(b), e);
            end
            last_x[id] = cyc;
        end
        stall[id] = v && !rd;
        held[id]  = int'(b);
        if (d) begin
            done_cnt[id]++;
            // transfer sampled before edge E, done visible after edge E+1
            chk({nm, "_done_latency"}, cyc - last_x[id], 2);
            chk({nm, "_busy_at_done"}, int'(bz), 0);
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitor_step(0, "a", rst_a, valid_a, ready_a, byte_a, busy_a, done_a);
        monitor_step(1, "b", rst_b, valid_b, ready_b, byte_b, busy_b, done_b);
        monitor_step(2, "c", rst_c, valid_c, ready_c, byte_c, busy_c, done_c);
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(int'(hc) == h && int'(vc) == v) && n < 1000) begin
            tick();
            n++;
        end
        chk("raster_wait_timeout", int'(n < 1000), 1);
    endtask

    task automatic wait_done(input int id, input int target);
        int n = 0;
        while (done_cnt[id] < target && n < 2000) begin
            tick();
            n++;
        end
        chk("done_reached", done_cnt[id], target);
    endtask

    task automatic pulse(input int id);
        case (id)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();
        chk("rst_byte_a", int'(byte_a), 0);  chk("rst_valid_a", int'(valid_a), 0);
        chk("rst_busy_a", int'(busy_a), 0);  chk("rst_done_a", int'(done_a), 0);
        chk("rst_ovf_a", int'(ovf_a), 0);
        chk("rst_valid_b", int'(valid_b), 0); chk("rst_busy_b", int'(busy_b), 0);
        chk("rst_valid_c", int'(valid_c), 0); chk("rst_ovf_c", int'(ovf_c), 0);

        // A1: mid-frame start waits for the next origin
        repeat (4) q_a.push_back(8'hAA);
        wait_pos(5, 1);
        pulse(0);
        wait_pos(0, 3);
        chk("a_busy_armed", int'(busy_a), 1);
        chk("a_nothing_before_origin", int'(valid_a), 0);
        wait_done(0, 1);
        chk("a_busy_after_done", int'(busy_a), 0);

        // A2: sparse pattern
        mode_a = 1'b1;
        q_a.push_back(8'h01); q_a.push_back(8'h00); q_a.push_back(8'h00); q_a.push_back(8'h80);
        wait_pos(5, 2);
        pulse(0);
        wait_done(0, 2);
        chk("a_overflow_clear", int'(ovf_a), 0);

        // A3: toggling backpressure
        mode_a  = 1'b0;
        rmode_a = 2;
        repeat (4) q_a.push_back(8'hAA);
        wait_pos(5, 2);
        pulse(0);
        wait_done(0, 3);

        // A4: asynchronous reset with two bytes queued
        rmode_a = 0;
        wait_pos(5, 2);
        pulse(0);
        wait_pos(20, 0);
        chk("a_queued_before_reset", int'(valid_a), 1);
        chk("a_busy_before_reset", int'(busy_a), 1);
        #1 rst_a = 1'b1;
        #1;
        chk("a_valid_in_reset", int'(valid_a), 0);
        chk("a_busy_in_reset", int'(busy_a), 0);
        repeat (3) tick();
        rst_a   = 1'b0;
        rmode_a = 1;
        repeat (4) q_a.push_back(8'hAA);
        wait_pos(5, 2);
        pulse(0);
        wait_done(0, 4);

        // B: CELL_SHIFT=2 samples every 4th pixel of row 0
        q_b.push_back(8'hCC);
        wait_pos(5, 2);
        pulse(1);
        wait_done(1, 1);

        // C: depth-2 FIFO overflow, then drain and restart
        q_c.push_back(8'h01); q_c.push_back(8'h02);
        wait_pos(5, 2);
        pulse(2);
        wait_pos(34, 0);
        chk("c_overflow_set", int'(ovf_c), 1);
        chk("c_valid_full", int'(valid_c), 1);
        chk("c_busy_drain", int'(busy_c), 1);
        repeat (5) tick();
        rmode_c = 1;
        wait_done(2, 1);
        chk("c_overflow_sticky", int'(ovf_c), 1);
        q_c.push_back(8'h01); q_c.push_back(8'h02); q_c.push_back(8'h04); q_c.push_back(8'h08);
        wait_pos(5, 2);
        pulse(2);
        tick();
        chk("c_overflow_cleared_by_start", int'(ovf_c), 0);
        wait_done(2, 2);
        chk("c_overflow_no_drop", int'(ovf_c), 0);

        repeat (10) tick();
        chk("a_leftover", q_a.size(), 0);
        chk("b_leftover", q_b.size(), 0);
        chk("c_leftover", q_c.size(), 0);
        chk("a_done_total", done_cnt[0], 4);
        chk("b_done_total", done_cnt[1], 1);
        chk("c_done_total", done_cnt[2], 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/board_snapshot_reader.md
Name: board_snapshot_reader

Overview:
- Reads back one full frame of the cell stream that life_logic emits in raster order (alive plus hcount/vcount/blank). This is the reader counterpart to the seeder's raster-order writer.
- Packs one sample per cell into bytes and buffers them in an internal FIFO.
- Presents the bytes on a valid/ready stream for a downstream storage writer, such as a future SD card saver.
- Sits beside the renderer and taps logic_hcount, logic_vcount, logic_blank and cell_alive.

Parameters:
- BOARD_W, 160, board width in cells; must be a multiple of 8.
- BOARD_H, 120, board height in cells.
- CELL_SHIFT, 2, log2 of pixels per cell edge; 0 means one pixel per cell.
- FIFO_DEPTH, 16, FIFO depth in bytes; must be a power of two, at least 2.

Ports:
- clk_in  in  1  system clock; 25 MHz pixel clock.
- rst_in  in  1  asynchronous, active-high reset.
- start_in  in  1  one-cycle pulse that arms a snapshot.
- hcount_in  in  11  pixel column of alive_in.
- vcount_in  in  10  pixel row of alive_in.
- blank_in  in  1  high outside the active video region.
- alive_in  in  1  cell state at (hcount_in, vcount_in).
- byte_out  out  8  FIFO head byte.
- byte_valid_out  out  1  FIFO non-empty.
- byte_ready_in  in  1  consumer accepts byte_out this cycle.
- busy_out  out  1  high in ARMED, CAPTURE and DRAIN.
- done_out  out  1  one-cycle pulse when a snapshot has fully drained.
- overflow_out  out  1  sticky flag: at least one byte was dropped.

Behaviour:
- Reset (async, rst_in=1): state IDLE; FIFO emptied; all outputs 0 (byte_out = 8'h00, byte_valid_out, busy_out, done_out, overflow_out); shift register and cell counters cleared. Reset mid-snapshot abandons it with no done_out pulse.
- Sample point: !blank_in, low CELL_SHIFT bits of both hcount_in and vcount_in zero, hcount_in>>CELL_SHIFT < BOARD_W, vcount_in>>CELL_SHIFT < BOARD_H.
- FSM IDLE: start_in=1 -> ARMED and overflow_out cleared. start_in is ignored in every other state.
- FSM ARMED: waits for the sample point at hcount_in=0, vcount_in=0. That cell is captured on the same edge and the FSM moves to CAPTURE. A mid-frame start therefore always waits for the next frame's origin.
- FSM CAPTURE, bit order: each sample point shifts alive_in in LSB-first, so bit i of a byte is cell x = 8k+i of the row.
- FSM CAPTURE, byte push: the 8th sample of a byte pushes {alive_in, shreg[7:1]} into the FIFO on that same edge.
- FSM CAPTURE, exit: after the sample of cell (BOARD_W-1, BOARD_H-1) and its push, the FSM moves to DRAIN. Total bytes per snapshot = BOARD_W*BOARD_H/8.
- FSM DRAIN: when the FIFO is empty -> done_out=1 for exactly one cycle, then IDLE.
- Latency: byte_valid_out rises in the cycle after the edge that sampled the byte's 8th cell, provided the FIFO was empty.
- Handshake: a transfer occurs on any edge with byte_valid_out && byte_ready_in. byte_out is show-ahead and holds stable while valid && !ready. byte_ready_in is don't-care while byte_valid_out=0.
- FIFO full: a push while full with no simultaneous pop drops the byte and sets overflow_out=1 until the next accepted start_in. Capture continues and the byte count still advances.
- FIFO full with simultaneous pop: push and pop on the same edge both succeed; occupancy is unchanged.
- Counters: cell x/y counters run modulo BOARD_W and BOARD_H. Sample points outside the board, and pixels repeated within a cell, are ignored.
- Frame boundary: the snapshot does not stop at a frame boundary before the last cell. Blanking periods simply produce no samples.

Test Plan:
- Params W=16, H=2, CELL_SHIFT=0, raster with alive = x[0] (odd columns alive); pulse start_in mid-frame, ready held at 1 -> nothing captured until origin; bytes 8'hAA x4 in order; done_out pulses once, 1 cycle after the 4th transfer; busy_out falls with it.
- Same params, alive=1 only at (0,0) and (15,1) -> bytes 8'h01, 8'h00, 8'h00, 8'h80; overflow_out=0.
- CELL_SHIFT=2, W=8, H=1, alive toggling every pixel -> only pixels x=0,4,...,28 on row 0 sampled; a single byte whose bits match alive at those pixels; vcount rows 1-3 ignored.
- FIFO_DEPTH=2, W=32, H=1, ready held 0 -> first two bytes retained, bytes 3-4 dropped, overflow_out=1. Then raise ready -> exactly 2 bytes drain, done_out pulses. A new start_in clears overflow_out.
- Backpressure: ready toggles 1-0-1 during CAPTURE -> byte_out stable while stalled; no loss, no duplication; 8'hAA sequence intact.
- Assert rst_in asynchronously mid-CAPTURE with 2 bytes queued -> byte_valid_out and busy_out drop immediately, no done_out pulse. After release, a fresh start yields a complete, correct snapshot.
